rom_loader: RTL and testbench

- Upstream feeder for the sm510 core.
- Accepts a byte stream from the host download bridge and writes it into a 4096x8 program ROM.
- Zero-fills every address above the highest address written, then releases the CPU from reset.
- Serves the CPU's rom_addr -> rom_data fetches with one-cycle registered latency, the timing the core expects.

---
 rtl/rom_loader_if.sv | 22 ++
 rtl/rom_loader.sv | 175 +++++++++++++++++
 tb/tb_rom_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// Download-bridge and CPU fetch bus for rom_loader.
// master = host bridge + CPU side, slave = the loader.
interface rom_loader_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  dl_active;
   logic                  dl_wr;
   logic [15:0]           dl_addr;
   logic [7:0]            dl_data;
   logic [ADDR_WIDTH-1:0] rom_addr;
   logic [7:0]            rom_data;

   modport master (
      output dl_active, dl_wr, dl_addr, dl_data, rom_addr,
      input  rom_data
   );

   modport slave (
      input  dl_active, dl_wr, dl_addr, dl_data, rom_addr,
      output rom_data
   );
endinterface

// File: rtl/rom_loader.sv
// Program ROM loader for the sm510: captures a host byte stream, zero-fills the
// unwritten tail, holds the CPU in reset, then releases it. Optional running
// byte checksum is enabled by defining ROM_LOADER_CHECKSUM_EN.
module rom_loader #(
   parameter int ROM_DEPTH  = 4096,
   parameter int ADDR_WIDTH = 12,
   parameter int RESET_HOLD = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   rom_loader_if.slave       bus,
   output logic              o_cpu_reset,
   output logic              o_loaded,
   output logic              o_overflow,
   output logic [7:0]        o_checksum
);

   localparam int HC_W = $clog2(RESET_HOLD + 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(ROM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(ROM_DEPTH - 1);
   localparam logic [HC_W-1:0]       HOLD_C  = HC_W'(RESET_HOLD - 1);

   typedef enum logic [2:0] {
      EMPTY   = 3'd0,
      LOADING = 3'd1,
      FILL    = 3'd2,
      HOLD    = 3'd3,
      RUN     = 3'd4
   } state_t;

   state_t                r_state;
   logic                  r_cpu_reset;
   logic                  r_loaded;
   logic                  r_overflow;
   logic [ADDR_WIDTH:0]   r_byte_count;
   logic [ADDR_WIDTH:0]   r_high_water;
   logic [ADDR_WIDTH-1:0] r_fill_ptr;
   logic [HC_W-1:0]       r_hold_cnt;
   logic [7:0]            r_rom_data;
   logic [7:0]            r_mem [ROM_DEPTH];

   logic                  w_in_range;
   logic                  w_accept;
   logic                  w_enter_load;
   logic [ADDR_WIDTH:0]   w_addr_p1;
   logic [ADDR_WIDTH:0]   w_bc_next;
   logic [ADDR_WIDTH:0]   w_hw_next;
   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [7:0]            w_wdata;

   assign w_in_range   = (32'(bus.dl_addr) < ROM_DEPTH);
   assign w_accept     = (r_state == LOADING) && bus.dl_wr && w_in_range;
   assign w_enter_load = bus.dl_active &&
                         ((r_state == EMPTY) || (r_state == HOLD) || (r_state == RUN));
   assign w_addr_p1    = {1'b0, bus.dl_addr[ADDR_WIDTH-1:0]} + 1'b1;

   // Counters as they stand after this cycle's write, so a byte accepted on
   // the cycle dl_active falls is included in the exit decision.
   always_comb begin
      w_bc_next = r_byte_count;
      w_hw_next = r_high_water;
      if (w_accept) begin
         if (r_byte_count != DEPTH_C)
            w_bc_next = r_byte_count + 1'b1;
         if (w_addr_p1 > r_high_water)
            w_hw_next = w_addr_p1;
      end
   end

   // Single write port shared by the download and the zero-fill.
   always_comb begin
      w_we    = w_accept || (r_state == FILL);
      w_waddr = bus.dl_addr[ADDR_WIDTH-1:0];
      w_wdata = bus.dl_data;
      if (r_state == FILL) begin
         w_waddr = r_fill_ptr;
         w_wdata = 8'h00;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we)
         r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_rom_data <= 8'h00;
      else
         r_rom_data <= r_mem[bus.rom_addr];
   end

   assign bus.rom_data = r_rom_data;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= EMPTY;
         r_cpu_reset  <= 1'b1;
         r_loaded     <= 1'b0;
         r_overflow   <= 1'b0;
         r_byte_count <= '0;
         r_high_water <= '0;
         r_fill_ptr   <= '0;
         r_hold_cnt   <= '0;
      end else begin
         r_cpu_reset <= 1'b1;
         r_loaded    <= 1'b0;
         if (w_enter_load) begin
            r_state      <= LOADING;
            r_byte_count <= '0;
            r_high_water <= '0;
            r_overflow   <= 1'b0;
         end else begin
            case (r_state)
               LOADING: begin
                  r_byte_count <= w_bc_next;
                  r_high_water <= w_hw_next;
                  if (bus.dl_wr && !w_in_range)
                     r_overflow <= 1'b1;
                  if (!bus.dl_active) begin
                     r_fill_ptr <= w_hw_next[ADDR_WIDTH-1:0];
                     r_hold_cnt <= '0;
                     if (w_bc_next == '0)
                        r_state <= EMPTY;
                     else if (w_hw_next == DEPTH_C)
                        r_state <= HOLD;
                     else
                        r_state <= FILL;
                  end
               end
               FILL: begin
                  if (r_fill_ptr == LAST_C) begin
                     r_state    <= HOLD;
                     r_hold_cnt <= '0;
                  end else begin
                     r_fill_ptr <= r_fill_ptr + 1'b1;
                  end
               end
               HOLD: begin
                  if (r_hold_cnt == HOLD_C)
                     r_state <= RUN;
                  else
                     r_hold_cnt <= r_hold_cnt + 1'b1;
               end
               RUN: begin
                  r_cpu_reset <= 1'b0;
                  r_loaded    <= 1'b1;
               end
               default: r_state <= EMPTY;
            endcase
         end
      end
   end

`ifdef ROM_LOADER_CHECKSUM_EN
   logic [7:0] r_checksum;

   always_ff @(posedge i_clk) begin
      if (i_reset || w_enter_load)
         r_checksum <= 8'h00;
      else if (w_accept)
         r_checksum <= r_checksum + bus.dl_data;
   end

   assign o_checksum = r_checksum;
`else
   assign o_checksum = 8'h00;
`endif

   assign o_cpu_reset = r_cpu_reset;
   assign o_loaded    = r_loaded;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: download, fill, hold timing, overflow, reload
// and mid-fill reset, with hand-computed expectations.
module tb_rom_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_reset, loaded, overflow;
   logic [7:0] checksum;
   int         n_run  = 0;
   int         n_fail = 0;

   rom_loader_if #(.ADDR_WIDTH(12)) bus ();

   rom_loader #(.ROM_DEPTH(4096), .ADDR_WIDTH(12), .RESET_HOLD(16)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .bus         (bus.slave),
      .o_cpu_reset (cpu_reset),
      .o_loaded    (loaded),
      .o_overflow  (overflow),
      .o_checksum  (checksum)
   );

   always #5 clk = ~clk;

`ifdef ROM_LOADER_CHECKSUM_EN
   localparam logic [7:0] CS3 = 8'h9C;
   localparam logic [7:0] CS1 = 8'h77;
`else
   localparam logic [7:0] CS3 = 8'h00;
   localparam logic [7:0] CS1 = 8'h00;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [7:0] exp);
      bus.rom_addr = a;
      tick();
      check(tag, 32'(bus.rom_data), 32'(exp));
   endtask

   // Full 4096-byte image, data = addr[7:0] ^ x; dl_active falls with the last byte.
   task automatic dl_full(input logic [7:0] x);
      logic [11:0] a;
      bus.dl_active = 1'b1;
      tick();
      for (int i = 0; i < 4096; i++) begin
         a = 12'(i);
         bus.dl_wr     = 1'b1;
         bus.dl_addr   = 16'(i);
         bus.dl_data   = a[7:0] ^ x;
         bus.dl_active = (i != 4095);
         tick();
      end
      bus.dl_wr = 1'b0;
   endtask

   initial begin
      bus.dl_active = 1'b0;
      bus.dl_wr     = 1'b0;
      bus.dl_addr   = '0;
      bus.dl_data   = '0;
      bus.rom_addr  = '0;
      repeat (3) tick();
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_loaded",    32'(loaded),    32'd0);
      check("rst_overflow",  32'(overflow),  32'd0);
      check("rst_rom_data",  32'(bus.rom_data), 32'h00);
      check("rst_checksum",  32'(checksum),  32'h00);
      rst = 1'b0;

      // Empty download pulse
      bus.dl_active = 1'b1;
      repeat (2) tick();
      bus.dl_active = 1'b0;
      repeat (30) tick();
      check("pulse_cpu_reset", 32'(cpu_reset), 32'd1);
      check("pulse_loaded",    32'(loaded),    32'd0);

      // Full download: no FILL, release RESET_HOLD+1 cycles after dl_active falls
      dl_full(8'h00);
      repeat (16) tick();
      check("full_hold_cpu_reset", 32'(cpu_reset), 32'd1);
      tick();
      check("full_cpu_reset", 32'(cpu_reset), 32'd0);
      check("full_loaded",    32'(loaded),    32'd1);
      check("full_byte_count", 32'(dut.r_byte_count), 32'd4096);
      check("full_checksum",  32'(checksum),  32'h00);
      rd("full_rd_0a5", 12'h0A5, 8'hA5);
      rd("full_rd_fff", 12'hFFF, 8'hFF);

      // Reload from RUN with 3 bytes over the nonzero image
      bus.dl_active = 1'b1;
      tick();
      check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
      check("reload_loaded",    32'(loaded),    32'd0);
      bus.dl_wr = 1'b1;
      bus.dl_addr = 16'h0000; bus.dl_data = 8'h12; tick();
      bus.dl_addr = 16'h0001; bus.dl_data = 8'h34; tick();
      bus.dl_addr = 16'h0002; bus.dl_data = 8'h56; bus.dl_active = 1'b0; tick();
      bus.dl_wr = 1'b0;
      repeat (4093 + 16) tick();
      check("fill3_hold_cpu_reset", 32'(cpu_reset), 32'd1);
      tick();
      check("fill3_cpu_reset", 32'(cpu_reset), 32'd0);
      check("fill3_loaded",    32'(loaded),    32'd1);
      check("fill3_checksum",  32'(checksum),  32'(CS3));
      check("fill3_byte_count", 32'(dut.r_byte_count), 32'd3);
      rd("fill3_rd_000", 12'h000, 8'h12);
      rd("fill3_rd_002", 12'h002, 8'h56);
      rd("fill3_rd_003", 12'h003, 8'h00);
      rd("fill3_rd_0a5", 12'h0A5, 8'h00);
      rd("fill3_rd_fff", 12'hFFF, 8'h00);

      // Out-of-range write plus one valid byte, then reset during FILL
      bus.dl_active = 1'b1;
      tick();
      bus.dl_wr = 1'b1;
      bus.dl_addr = 16'h1000; bus.dl_data = 8'hFF; tick();
      bus.dl_addr = 16'h0005; bus.dl_data = 8'h77; bus.dl_active = 1'b0; tick();
      bus.dl_wr = 1'b0;
      check("ovf_overflow",   32'(overflow), 32'd1);
      check("ovf_byte_count", 32'(dut.r_byte_count), 32'd1);
      check("ovf_checksum",   32'(checksum), 32'(CS1));
      rd("ovf_rd_000", 12'h000, 8'h12);
      rd("ovf_rd_005", 12'h005, 8'h77);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("midrst_loaded",    32'(loaded),    32'd0);
      check("midrst_overflow",  32'(overflow),  32'd0);
      check("midrst_checksum",  32'(checksum),  32'h00);
      repeat (5000) tick();
      check("midrst_stays_reset", 32'(cpu_reset), 32'd1);

      // Next full download completes normally
      dl_full(8'h5A);
      repeat (16) tick();
      check("full2_hold_cpu_reset", 32'(cpu_reset), 32'd1);
      tick();
      check("full2_cpu_reset", 32'(cpu_reset), 32'd0);
      check("full2_loaded",    32'(loaded),    32'd1);
      check("full2_checksum",  32'(checksum),  32'h00);
      rd("full2_rd_0a5", 12'h0A5, 8'hFF);
      rd("full2_rd_fff", 12'hFFF, 8'hA5);

      // Writes outside LOADING are ignored
      bus.dl_wr = 1'b1; bus.dl_addr = 16'h0010; bus.dl_data = 8'hEE; tick();
      bus.dl_wr = 1'b0;
      rd("ignored_wr_010", 12'h010, 8'h4A);
      check("ignored_wr_loaded", 32'(loaded), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
